// File: rtl/req_ack_pkg.sv
// Shared definitions for the req/ack pull-protocol responder.
// ack is a one-cycle pulse, and dout must be stable for at least one cycle before ack rises.
package req_ack_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STAGED = 2'd1,
    ACK    = 2'd2
  } state_t;

  // Plain encodings for Verilog-2001 code that cannot import the enum.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STAGED = 2'd1;
  localparam logic [1:0] ST_ACK    = 2'd2;

endpackage

// File: rtl/req_ack_fifo_core.sv
// Circular FIFO storage with a registered full flag and an occupancy count.
// head is a combinational read at the read pointer. Pushes while full and pops while empty are ignored.
module req_ack_fifo_core #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] head,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  full
);

  localparam logic [ADDR_WIDTH:0] ONE        = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] FULL_LEVEL = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   wr_cnt;
  logic [ADDR_WIDTH:0]   rd_cnt;
  logic [ADDR_WIDTH:0]   level_next;
  logic                  do_push;
  logic                  do_pop;

  // The counts carry one extra bit, so wr_cnt - rd_cnt tells a full FIFO apart from an empty one.
  assign level   = wr_cnt - rd_cnt;
  assign do_push = push & ~full;
  assign do_pop  = pop & (level != '0);
  assign head    = mem[rd_cnt[ADDR_WIDTH-1:0]];

  always_comb begin
    level_next = level;
    if (do_push && !do_pop) begin
      level_next = level + ONE;
    end else if (!do_push && do_pop) begin
      level_next = level - ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
      full   <= 1'b0;
    end else begin
      if (do_push) wr_cnt <= wr_cnt + ONE;
      if (do_pop)  rd_cnt <= rd_cnt + ONE;
      full <= (level_next == FULL_LEVEL);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_cnt[ADDR_WIDTH-1:0]] <= wr_data;
  end

endmodule

// File: rtl/req_ack_source_fifo.sv
// Responder end of the req/ack pull protocol. A local writer fills the FIFO.
// Each word is staged on dout for at least one cycle and is then handed over with a one-cycle ack.
module req_ack_source_fifo
  import req_ack_pkg::*;
#(
  parameter int              DATA_WIDTH    = 32,
  parameter int              DEPTH         = 16,
  parameter int              ADDR_WIDTH    = $clog2(DEPTH),
  parameter logic [DATA_WIDTH-1:0] INITIAL_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overflow,
  input  logic                  hold,
  input  logic                  req,
  output logic                  ack,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [31:0]           count
);

  state_t                state_q;
  state_t                state_d;
  logic                  pop;
  logic                  load;
  logic                  fire;
  logic [DATA_WIDTH-1:0] head;

  req_ack_fifo_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .push    (wr_en),
    .pop     (pop),
    .wr_data (wr_data),
    .head    (head),
    .level   (level),
    .full    (full)
  );

  // dout is loaded only when leaving IDLE or ACK, never on the edge that raises ack.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    load    = 1'b0;
    fire    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (level != '0) begin
          pop     = 1'b1;
          load    = 1'b1;
          state_d = STAGED;
        end
      end
      STAGED: begin
        if (req && !hold) begin
          fire    = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        if (level != '0) begin
          pop     = 1'b1;
          load    = 1'b1;
          state_d = STAGED;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ack      <= 1'b0;
      dout     <= INITIAL_VALUE;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      state_q <= state_d;
      ack     <= fire;
      if (load) dout <= head;
      if (fire) count <= count + 32'd1;
      // full is the registered flag, so a pop on the same edge does not let a push through.
      if (wr_en && full) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_req_ack_source_fifo.sv
// Directed self-checking bench for req_ack_source_fifo.
// Each task drives one scenario and checks its expected values inline.
module tb_req_ack_source_fifo;

  localparam int          DW    = 32;
  localparam int          DEPTH = 16;
  localparam int          AW    = 4;
  localparam logic [31:0] INIT  = 32'hA5A5_0001;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          full;
  logic [AW:0]   level;
  logic          overflow;
  logic          hold;
  logic          req;
  logic          ack;
  logic [DW-1:0] dout;
  logic [31:0]   count;

  int total = 0;
  int bad   = 0;

  req_ack_source_fifo #(
    .DATA_WIDTH    (DW),
    .DEPTH         (DEPTH),
    .INITIAL_VALUE (INIT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .level    (level),
    .overflow (overflow),
    .hold     (hold),
    .req      (req),
    .ack      (ack),
    .dout     (dout),
    .count    (count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; wr_en = 1'b0; wr_data = '0; hold = 1'b0; req = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] d);
    wr_en = 1'b1; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (ack !== 1'b0) begin bad++; $display("FAIL reset_ack got=%0d want=0", ack); end
    total++; if (dout !== INIT) begin bad++; $display("FAIL reset_dout got=%h want=%h", dout, INIT); end
    total++; if (count !== 32'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
    total++; if (level !== 5'd0) begin bad++; $display("FAIL reset_level got=%0d want=0", level); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%0d want=0", full); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%0d want=0", overflow); end
  endtask

  // Push 5,6,7 back to back with req tied high. The acks land after edges 2, 4 and 6.
  task automatic test_stream();
    logic [31:0] prev_dout;
    logic        prev_ack;
    logic        exp_ack;
    logic [31:0] exp_d;
    do_reset();
    req = 1'b1;
    prev_dout = dout; prev_ack = ack;
    for (int c = 0; c < 10; c++) begin
      wr_en = (c < 3); wr_data = 32'(5 + c);
      tick();
      wr_en = 1'b0;
      exp_ack = (c == 2) || (c == 4) || (c == 6);
      total++; if (ack !== exp_ack) begin bad++; $display("FAIL stream_ack cyc=%0d got=%0d want=%0d", c, ack, exp_ack); end
      if (ack) begin
        exp_d = 32'(5 + (c - 2) / 2);
        total++; if (dout !== exp_d) begin bad++; $display("FAIL stream_dout cyc=%0d got=%0d want=%0d", c, dout, exp_d); end
        total++; if (dout !== prev_dout || prev_ack !== 1'b0) begin bad++; $display("FAIL stream_stable cyc=%0d got=%0d prev=%0d want equal and prev_ack=0", c, dout, prev_dout); end
      end
      prev_dout = dout; prev_ack = ack;
    end
    req = 1'b0;
    total++; if (count !== 32'd3) begin bad++; $display("FAIL stream_count got=%0d want=3", count); end
  endtask

  // Sixteen pushes give one staged word and 15 queued. The 17th push fills the FIFO and the 18th is dropped.
  task automatic test_full_overflow();
    int n;
    do_reset();
    for (int i = 0; i < 16; i++) push_word(32'(100 + i));
    total++; if (level !== 5'd15) begin bad++; $display("FAIL fill_level got=%0d want=15", level); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL fill_full15 got=%0d want=0", full); end
    total++; if (dout !== 32'd100) begin bad++; $display("FAIL fill_staged got=%0d want=100", dout); end
    push_word(32'd116);
    total++; if (level !== 5'd16 || full !== 1'b1) begin bad++; $display("FAIL fill_full got level=%0d full=%0d want 16/1", level, full); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fill_no_overflow got=%0d want=0", overflow); end
    push_word(32'd117);
    total++; if (overflow !== 1'b1 || level !== 5'd16) begin bad++; $display("FAIL overflow got ovf=%0d level=%0d want 1/16", overflow, level); end
    req = 1'b1; n = 0;
    for (int c = 0; c < 80 && n < 17; c++) begin
      tick();
      if (ack) begin
        total++; if (dout !== 32'(100 + n)) begin bad++; $display("FAIL drain_data got=%0d want=%0d", dout, 100 + n); end
        n++;
      end
    end
    total++; if (n !== 17) begin bad++; $display("FAIL drain_words got=%0d want=17", n); end
    for (int c = 0; c < 6; c++) tick();
    total++; if (count !== 32'd17 || level !== 5'd0) begin bad++; $display("FAIL drain_end got count=%0d level=%0d want 17/0", count, level); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL overflow_sticky got=%0d want=1", overflow); end
    req = 1'b0;
  endtask

  // The pop out of ACK coincides with a push at level 15, so level and full stay put.
  task automatic test_push_pop();
    int n;
    do_reset();
    for (int i = 0; i < 16; i++) push_word(32'(200 + i));
    req = 1'b1;
    tick();
    req = 1'b0;
    total++; if (ack !== 1'b1 || dout !== 32'd200) begin bad++; $display("FAIL pp_ack got ack=%0d dout=%0d want 1/200", ack, dout); end
    push_word(32'd216);
    total++; if (level !== 5'd15 || full !== 1'b0) begin bad++; $display("FAIL pp_level got level=%0d full=%0d want 15/0", level, full); end
    total++; if (dout !== 32'd201 || ack !== 1'b0) begin bad++; $display("FAIL pp_restage got dout=%0d ack=%0d want 201/0", dout, ack); end
    req = 1'b1; n = 0;
    for (int c = 0; c < 80 && n < 16; c++) begin
      tick();
      if (ack) begin
        total++; if (dout !== 32'(201 + n)) begin bad++; $display("FAIL pp_drain got=%0d want=%0d", dout, 201 + n); end
        n++;
      end
    end
    total++; if (n !== 16) begin bad++; $display("FAIL pp_words got=%0d want=16", n); end
    req = 1'b0;
  endtask

  // req toggles every cycle. With hold high no ack may appear, and afterwards each word is acked exactly once.
  task automatic test_hold_toggle();
    int   n;
    logic prev_ack;
    do_reset();
    push_word(32'd300); push_word(32'd301); push_word(32'd302);
    tick(); tick();
    hold = 1'b1;
    for (int c = 0; c < 4; c++) begin
      req = ~req;
      tick();
      total++; if (ack !== 1'b0) begin bad++; $display("FAIL hold_ack cyc=%0d got=%0d want=0", c, ack); end
    end
    hold = 1'b0; n = 0; prev_ack = 1'b0;
    for (int c = 0; c < 24; c++) begin
      req = ~req;
      tick();
      if (ack) begin
        total++; if (dout !== 32'(300 + n) || prev_ack !== 1'b0) begin bad++; $display("FAIL toggle_data got=%0d prev_ack=%0d want=%0d/0", dout, prev_ack, 300 + n); end
        n++;
      end
      prev_ack = ack;
    end
    total++; if (n !== 3 || count !== 32'd3) begin bad++; $display("FAIL toggle_words got n=%0d count=%0d want 3/3", n, count); end
    req = 1'b0;
  endtask

  // Reset asserted during the ack cycle with three words still queued.
  task automatic test_reset_mid_ack();
    int seen;
    do_reset();
    for (int i = 0; i < 4; i++) push_word(32'(400 + i));
    tick();
    req = 1'b1; seen = 0;
    for (int c = 0; c < 10 && seen == 0; c++) begin
      tick();
      if (ack) seen = 1;
    end
    total++; if (seen !== 1 || level !== 5'd3) begin bad++; $display("FAIL rma_ack got seen=%0d level=%0d want 1/3", seen, level); end
    rst = 1'b1; req = 1'b0;
    tick();
    rst = 1'b0;
    total++; if (ack !== 1'b0 || dout !== INIT) begin bad++; $display("FAIL rma_out got ack=%0d dout=%h want 0/%h", ack, dout, INIT); end
    total++; if (level !== 5'd0 || count !== 32'd0) begin bad++; $display("FAIL rma_state got level=%0d count=%0d want 0/0", level, count); end
    push_word(32'd500);
    req = 1'b1; seen = 0;
    for (int c = 0; c < 10 && seen == 0; c++) begin
      tick();
      if (ack) seen = 1;
    end
    total++; if (seen !== 1 || dout !== 32'd500 || count !== 32'd1) begin bad++; $display("FAIL rma_restart got seen=%0d dout=%0d count=%0d want 1/500/1", seen, dout, count); end
    req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_full_overflow();
    test_push_pop();
    test_hold_toggle();
    test_reset_mid_ack();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
